// File: rtl/flow_table_ctrl.sv
// Flow table RAM owner: arbitrates datapath lookup/auto-learn against CSR read/write/clear, keeps saturating stats.
// Lookup result 2 cycles after accept (1 per 3 cycles peak); CSR ack 1-2 cycles after accept, clear 2**AW; lk_ready low while busy.
module flow_table_ctrl #(
  parameter int KEY_WIDTH  = 96,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lk_valid,
  input  logic [KEY_WIDTH-1:0]  lk_key,
  output logic                  lk_ready,
  input  logic                  learn_en,
  output logic                  res_valid,
  output logic                  res_hit,
  output logic                  res_learned,
  output logic [ADDR_WIDTH-1:0] res_idx,
  input  logic                  cfg_req,
  input  logic [1:0]            cfg_op,
  input  logic [ADDR_WIDTH-1:0] cfg_idx,
  input  logic                  cfg_wvld,
  input  logic [KEY_WIDTH-1:0]  cfg_wkey,
  output logic                  cfg_ack,
  output logic                  cfg_rvld,
  output logic [KEY_WIDTH-1:0]  cfg_rkey,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [KEY_WIDTH:0]    mem_wdata,
  input  logic [KEY_WIDTH:0]    mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic [CNT_WIDTH-1:0]  learn_cnt,
  output logic [CNT_WIDTH-1:0]  coll_cnt
);
  typedef struct packed {
    logic                 vld;
    logic [KEY_WIDTH-1:0] key;
  } entry_t;

  typedef enum logic [2:0] {IDLE, LK_RD, LK_CMP, CFG_RD, CFG_DONE, CLR} state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam int NSLICE = (KEY_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;

  state_t                  state, state_nxt;
  logic                    prio_csr;
  logic [KEY_WIDTH-1:0]    cap_key;
  logic                    cap_vld, cap_learn;
  logic [1:0]              cap_op;
  logic [ADDR_WIDTH-1:0]   cap_idx, clr_addr, lk_hash;
  logic [NSLICE*ADDR_WIDTH-1:0] key_pad;
  logic                    grant_lk, grant_cfg, hit, learn_wr;
  entry_t                  rd_ent, wr_ent;

  assign rd_ent    = entry_t'(mem_rdata);
  assign mem_wdata = wr_ent;
  assign busy      = (state != IDLE);
  assign lk_ready  = grant_lk;

  always_comb begin
    key_pad = '0;
    key_pad[KEY_WIDTH-1:0] = lk_key;
    lk_hash = '0;
    for (int i = 0; i < NSLICE; i++) lk_hash ^= key_pad[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // On contention the pointer picks the side; a lone requester always wins.
  always_comb begin
    grant_lk  = 1'b0;
    grant_cfg = 1'b0;
    if (state == IDLE) begin
      grant_cfg = cfg_req && (!lk_valid || prio_csr);
      grant_lk  = lk_valid && (!cfg_req || !prio_csr);
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    wr_ent      = '0;
    res_valid   = 1'b0;
    res_hit     = 1'b0;
    res_learned = 1'b0;
    res_idx     = '0;
    cfg_ack     = 1'b0;
    hit         = rd_ent.vld && (rd_ent.key == cap_key);
    learn_wr    = !rd_ent.vld && cap_learn;
    case (state)
      IDLE: begin
        if (grant_lk) state_nxt = LK_RD;
        else if (grant_cfg) begin
          if (cfg_op == OP_CLR) state_nxt = CLR;
          else if (cfg_op == OP_RD || cfg_op == OP_WR) state_nxt = CFG_RD;
          else state_nxt = CFG_DONE;
        end
      end
      LK_RD: begin
        mem_en    = 1'b1;
        mem_addr  = cap_idx;
        state_nxt = LK_CMP;
      end
      LK_CMP: begin
        res_valid   = 1'b1;
        res_hit     = hit;
        res_idx     = cap_idx;
        res_learned = learn_wr;
        if (learn_wr) begin
          mem_en     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = cap_idx;
          wr_ent.vld = 1'b1;
          wr_ent.key = cap_key;
        end
        state_nxt = IDLE;
      end
      CFG_RD: begin
        mem_en     = 1'b1;
        mem_we     = (cap_op == OP_WR);
        mem_addr   = cap_idx;
        wr_ent.vld = cap_vld;
        wr_ent.key = cap_key;
        state_nxt  = CFG_DONE;
      end
      CFG_DONE: begin
        cfg_ack   = 1'b1;
        state_nxt = IDLE;
      end
      CLR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_addr;
        if (clr_addr == '1) begin
          cfg_ack   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio_csr  <= 1'b1;
      cap_key   <= '0;
      cap_vld   <= 1'b0;
      cap_learn <= 1'b0;
      cap_op    <= '0;
      cap_idx   <= '0;
      clr_addr  <= '0;
      cfg_rvld  <= 1'b0;
      cfg_rkey  <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      learn_cnt <= '0;
      coll_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && lk_valid && cfg_req) prio_csr <= !prio_csr;
      // One capture register set serves whichever side was granted.
      if (grant_lk) begin
        cap_key   <= lk_key;
        cap_learn <= learn_en;
        cap_idx   <= lk_hash;
      end else if (grant_cfg) begin
        cap_key  <= cfg_wkey;
        cap_vld  <= cfg_wvld;
        cap_op   <= cfg_op;
        cap_idx  <= cfg_idx;
        clr_addr <= '0;
      end
      if (state == CLR) clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (state == CFG_DONE && cap_op == OP_RD) begin
        cfg_rvld <= rd_ent.vld;
        cfg_rkey <= rd_ent.key;
      end
      if (state == LK_CMP) begin
        if (hit) hit_cnt <= sat_inc(hit_cnt);
        else miss_cnt <= sat_inc(miss_cnt);
        if (learn_wr) learn_cnt <= sat_inc(learn_cnt);
        if (rd_ent.vld && !hit) coll_cnt <= sat_inc(coll_cnt);
      end
    end
  end
endmodule

// File: doc/flow_table_ctrl.md
Name: flow_table_ctrl

Overview:
Controller that owns the single-port flow table RAM and shares it between the datapath and the CSR path. The datapath presents the 96-bit flow key produced by flow_key_gen for lookup with optional auto-learn. The CSR path reads, writes or bulk-clears entries. The table is direct-mapped on an XOR-fold hash of the key; the controller keeps saturating hit, miss, learn and collision statistics.

Parameters:
KEY_WIDTH, 96, flow key width (must match flow_key_gen output)
ADDR_WIDTH, 8, table index width; table depth = 2**ADDR_WIDTH
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lk_valid  in  1  lookup request valid
lk_key  in  KEY_WIDTH  flow key to look up
lk_ready  out  1  lookup request accepted when lk_valid&lk_ready
learn_en  in  1  install key on empty-slot miss
res_valid  out  1  one-cycle result strobe
res_hit  out  1  key found at hashed index
res_learned  out  1  key installed by this lookup
res_idx  out  ADDR_WIDTH  hashed index of this lookup
cfg_req  in  1  CSR request, held until cfg_ack
cfg_op  in  2  00 read, 01 write, 10 clear-all, 11 reserved (acked, no effect)
cfg_idx  in  ADDR_WIDTH  entry index for read/write
cfg_wvld  in  1  valid bit to write
cfg_wkey  in  KEY_WIDTH  key to write
cfg_ack  out  1  one-cycle completion strobe
cfg_rvld  out  1  read-back valid bit (held until next read)
cfg_rkey  out  KEY_WIDTH  read-back key (held until next read)
busy  out  1  high in every state except IDLE
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  KEY_WIDTH+1  {valid, key}
mem_rdata  in  KEY_WIDTH+1  {valid, key}; valid 1 cycle after mem_en&~mem_we
hit_cnt, miss_cnt, learn_cnt, coll_cnt  out  CNT_WIDTH each  statistics

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, cfg_rkey/cfg_rvld 0, priority pointer = CSR.
- Hash: zero-pad the key to a multiple of ADDR_WIDTH, then XOR all ADDR_WIDTH-bit slices. Example: AW=8, key 96'h1 -> 0x01; key 96'h100 -> 0x01.
- FSM states: IDLE, LK_RD, LK_CMP, CFG_RD, CFG_DONE, CLR.
- IDLE arbitration:
  - If both requesters are pending, grant per the alternating pointer, then flip the pointer to the other side. A single pending requester is always granted.
  - lk_ready is combinational: high in IDLE when lookup is granted (no cfg_req, or the pointer favours lookup); 0 in all other states.
- Lookup (accept at cycle T):
  - T+1 (LK_RD): mem_en=1, mem_we=0, mem_addr=hash.
  - T+2 (LK_CMP): compare. Hit = rdata.valid and rdata.key == captured key. res_valid=1; res_idx=hash.
  - Hit: res_hit=1, hit_cnt++.
  - Miss: miss_cnt++.
    - Slot empty and learn_en sampled at T: same cycle mem_en=mem_we=1, wdata={1,key}, res_learned=1, learn_cnt++.
    - Slot valid with a different key: coll_cnt++, no write.
  - Return to IDLE at T+3. Peak rate is one lookup per 3 cycles.
- CSR read/write (accept at T):
  - T+1 (CFG_RD): mem_en=1, mem_addr=cfg_idx; mem_we=1 and wdata={cfg_wvld,cfg_wkey} for write.
  - T+2 (CFG_DONE): cfg_ack=1. For read, cfg_rvld/cfg_rkey are loaded from mem_rdata.
  - Return to IDLE.
- Clear (accept at T): CLR writes {0,0} to addresses 0..2**AW-1, one per cycle, starting at T+1. cfg_ack pulses on the cycle of the last write; IDLE follows. Counters are not cleared. Lookups are stalled throughout (lk_ready=0).
- Reserved op: acked at T+1, no RAM access.
- Counters saturate at all-ones; no wrap.
- A write to the same index as a prior lookup learn is ordered by grant order; last write wins.
- Async reset mid-operation aborts immediately. No result/ack is emitted for the aborted request. A partial clear is not resumed.
- mem_en=0 outside the cycles above.

Test Plan:
- Reset, empty table, learn_en=1, lookup key 96'h1 -> res_valid at T+2, hit=0, learned=1, idx=0x01; RAM[1]={1,96'h1}; miss_cnt=1, learn_cnt=1.
- Repeat lookup 96'h1 -> hit=1, learned=0, hit_cnt=1; then lookup 96'h100 -> hit=0, learned=0, coll_cnt=1, RAM[1] unchanged.
- CSR write idx 0x05 {1,96'hABCD}, then CSR read idx 0x05 -> cfg_ack 2 cycles after each accept; cfg_rvld=1, cfg_rkey=96'hABCD.
- lk_valid and cfg_req held together for 4 grants -> grants alternate CSR, LK, CSR, LK; lk_ready never asserted while the CSR side is being served.
- CSR clear with AW=4 -> 16 consecutive mem_we cycles over addresses 0..15, cfg_ack with the addr-15 write, busy for 16 cycles, lk_ready=0 throughout; a subsequent lookup of 96'h1 misses.
- Force hit_cnt to all-ones then hit again -> stays all-ones; assert rst during LK_RD -> no res_valid, all outputs 0 next cycle.
